pll_seq_ctrl: RTL and testbench



---
 rtl/pll_seq_pkg.sv | 26 ++
 rtl/pll_seq_timer.sv | 28 ++
 rtl/pll_seq_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_pll_seq_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL power-up / reprogramming sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      ST_PWRDN,
      ST_SEL_REF,
      ST_RST,
      ST_LOCK_WAIT,
      ST_SEL_PLL,
      ST_LOCKED,
      ST_ERROR
   } state_e;

   localparam bit RELOCK_OFF  = 1'b0;
   localparam bit RELOCK_AUTO = 1'b1;

   // One shared timer covers every hold period, so it is sized for the longest one.
   function automatic int cnt_w(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/pll_seq_timer.sv
// Loadable down-counter; done pulses in the last cycle of a load-cycle hold period.
module pll_seq_timer #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] load,
   output logic             done
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else if (start)
         cnt <= load - ONE;
      else if (cnt != '0)
         cnt <= cnt - ONE;
   end

   // start is a registered pulse, so its own cycle already counts as the first one.
   assign done = start ? (load == ONE) : (cnt == ONE);

endmodule

// File: rtl/pll_seq_ctrl.sv
// PLL sequencer: parks the output on refclk, resets and reconfigures the PLL,
// waits for a slip-free lock window, switches over and watches for slips.
module pll_seq_ctrl
   import pll_seq_pkg::*;
#(
   parameter int CLKR_W      = 4,
   parameter int CLKF_W      = 6,
   parameter int CLKOD_W     = 4,
   parameter int BWADJ_W     = 6,
   parameter int SW_CYC      = 8,
   parameter int RST_CYC     = 16,
   parameter int LOCK_CYC    = 2048,
   parameter int SLIP_MAX    = 3,
   parameter bit AUTO_RELOCK = RELOCK_AUTO
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic               req_pwrdn,
   input  logic [CLKR_W-1:0]  req_clkr,
   input  logic [CLKF_W-1:0]  req_clkf,
   input  logic [CLKOD_W-1:0] req_clkod,
   input  logic [BWADJ_W-1:0] req_bwadj,
   input  logic               req_intfb,
   input  logic               req_bypass,
   input  logic               rfslip,
   input  logic               fbslip,
   output logic [CLKR_W-1:0]  pll_clkr,
   output logic [CLKF_W-1:0]  pll_clkf,
   output logic [CLKOD_W-1:0] pll_clkod,
   output logic [BWADJ_W-1:0] pll_bwadj,
   output logic               pll_intfb,
   output logic               pll_bypass,
   output logic               pll_reset,
   output logic               pll_pwrdn,
   output logic               clk_sel,
   output logic               locked,
   output logic               busy,
   output logic               err,
   output logic [7:0]         relock_cnt
);

   localparam int CNT_W  = cnt_w(SW_CYC, RST_CYC, LOCK_CYC);
   localparam int SLIP_W = $clog2(SLIP_MAX + 1);
   localparam logic [CNT_W-1:0]  SW_L      = CNT_W'(SW_CYC);
   localparam logic [CNT_W-1:0]  RST_L     = CNT_W'(RST_CYC);
   localparam logic [CNT_W-1:0]  LOCK_L    = CNT_W'(LOCK_CYC);
   localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_MAX - 1);

   state_e             state;
   logic               tmr_start, tmr_done;
   logic [CNT_W-1:0]   tmr_load;
   logic [SLIP_W-1:0]  slip_cnt;
   logic               sh_pwrdn, sh_intfb, sh_bypass;
   logic [CLKR_W-1:0]  sh_clkr;
   logic [CLKF_W-1:0]  sh_clkf;
   logic [CLKOD_W-1:0] sh_clkod;
   logic [BWADJ_W-1:0] sh_bwadj;
   logic               slip, accept;

   assign slip      = rfslip | fbslip;
   assign req_ready = (state == ST_PWRDN) || (state == ST_LOCKED) || (state == ST_ERROR);
   assign accept    = req_valid & req_ready;

   pll_seq_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .start (tmr_start),
      .load  (tmr_load),
      .done  (tmr_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_PWRDN;
         tmr_start  <= 1'b0;
         tmr_load   <= '0;
         slip_cnt   <= '0;
         sh_pwrdn   <= 1'b0;
         sh_clkr    <= '0;
         sh_clkf    <= '0;
         sh_clkod   <= '0;
         sh_bwadj   <= '0;
         sh_intfb   <= 1'b0;
         sh_bypass  <= 1'b0;
         pll_clkr   <= '0;
         pll_clkf   <= '0;
         pll_clkod  <= '0;
         pll_bwadj  <= '0;
         pll_intfb  <= 1'b0;
         pll_bypass <= 1'b0;
         pll_reset  <= 1'b1;
         pll_pwrdn  <= 1'b1;
         clk_sel    <= 1'b0;
         locked     <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         relock_cnt <= '0;
      end else begin
         tmr_start <= 1'b0;
         // A new request outranks a slip seen in the same cycle.
         if (accept) begin
            sh_pwrdn  <= req_pwrdn;
            sh_clkr   <= req_clkr;
            sh_clkf   <= req_clkf;
            sh_clkod  <= req_clkod;
            sh_bwadj  <= req_bwadj;
            sh_intfb  <= req_intfb;
            sh_bypass <= req_bypass;
            err       <= 1'b0;
            clk_sel   <= 1'b0;
            locked    <= 1'b0;
            busy      <= 1'b1;
            tmr_start <= 1'b1;
            tmr_load  <= SW_L;
            state     <= ST_SEL_REF;
         end else begin
            unique case (state)
               ST_SEL_REF: if (tmr_done) begin
                  pll_reset <= 1'b1;
                  if (sh_pwrdn) begin
                     pll_pwrdn <= 1'b1;
                     busy      <= 1'b0;
                     state     <= ST_PWRDN;
                  end else begin
                     pll_pwrdn  <= 1'b0;
                     pll_clkr   <= sh_clkr;
                     pll_clkf   <= sh_clkf;
                     pll_clkod  <= sh_clkod;
                     pll_bwadj  <= sh_bwadj;
                     pll_intfb  <= sh_intfb;
                     pll_bypass <= sh_bypass;
                     tmr_start  <= 1'b1;
                     tmr_load   <= RST_L;
                     state      <= ST_RST;
                  end
               end
               ST_RST: if (tmr_done) begin
                  pll_reset <= 1'b0;
                  tmr_start <= 1'b1;
                  if (sh_bypass) begin
                     clk_sel  <= 1'b1;
                     tmr_load <= SW_L;
                     state    <= ST_SEL_PLL;
                  end else begin
                     slip_cnt <= '0;
                     tmr_load <= LOCK_L;
                     state    <= ST_LOCK_WAIT;
                  end
               end
               ST_LOCK_WAIT: begin
                  if (slip) begin
                     if (slip_cnt == SLIP_LAST) begin
                        clk_sel   <= 1'b0;
                        pll_reset <= 1'b1;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_ERROR;
                     end else begin
                        slip_cnt  <= slip_cnt + SLIP_W'(1);
                        tmr_start <= 1'b1;
                        tmr_load  <= LOCK_L;
                     end
                  end else if (tmr_done) begin
                     clk_sel   <= 1'b1;
                     tmr_start <= 1'b1;
                     tmr_load  <= SW_L;
                     state     <= ST_SEL_PLL;
                  end
               end
               ST_SEL_PLL: if (tmr_done) begin
                  locked <= 1'b1;
                  busy   <= 1'b0;
                  state  <= ST_LOCKED;
               end
               ST_LOCKED: if (slip && !sh_bypass) begin
                  clk_sel <= 1'b0;
                  locked  <= 1'b0;
                  if (AUTO_RELOCK == RELOCK_AUTO) begin
                     if (relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
                     busy      <= 1'b1;
                     tmr_start <= 1'b1;
                     tmr_load  <= SW_L;
                     state     <= ST_SEL_REF;
                  end else begin
                     pll_reset <= 1'b1;
                     err       <= 1'b1;
                     state     <= ST_ERROR;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Bench for pll_seq_ctrl: table of requests plus hand sequences for slips, relock and reset.
module tb_pll_seq_ctrl;
   import pll_seq_pkg::*;

   typedef struct packed {
      logic [3:0] clkr;
      logic [5:0] clkf;
      logic [3:0] clkod;
      logic [5:0] bwadj;
      logic       intfb;
      logic       bypass;
   } cfg_t;

   typedef struct {
      logic pwrdn;
      cfg_t req;
      int   lat;
      int   rst_fall;
      int   sel_rise;
      logic x_locked;
      logic x_pwrdn;
      cfg_t x_cfg;
   } vec_t;

   typedef struct {
      int   done_cyc;
      int   rst_fall;
      int   sel_rise;
      logic locked;
      logic err;
      logic pwrdn;
      cfg_t cfg;
   } sb_t;

   logic       clk = 1'b0, rst = 1'b1;
   logic       req_valid = 1'b0, req_ready, req_pwrdn = 1'b0;
   logic [3:0] req_clkr = '0, req_clkod = '0;
   logic [5:0] req_clkf = '0, req_bwadj = '0;
   logic       req_intfb = 1'b0, req_bypass = 1'b0, rfslip = 1'b0, fbslip = 1'b0;
   logic [3:0] pll_clkr, pll_clkod;
   logic [5:0] pll_clkf, pll_bwadj;
   logic       pll_intfb, pll_bypass, pll_reset, pll_pwrdn, clk_sel, locked, busy, err;
   logic [7:0] relock_cnt;
   cfg_t       act_cfg;

   pll_seq_ctrl #(
      .SW_CYC(2), .RST_CYC(4), .LOCK_CYC(32), .SLIP_MAX(3), .AUTO_RELOCK(1'b1)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_pwrdn(req_pwrdn), .req_clkr(req_clkr), .req_clkf(req_clkf),
      .req_clkod(req_clkod), .req_bwadj(req_bwadj), .req_intfb(req_intfb),
      .req_bypass(req_bypass), .rfslip(rfslip), .fbslip(fbslip),
      .pll_clkr(pll_clkr), .pll_clkf(pll_clkf), .pll_clkod(pll_clkod),
      .pll_bwadj(pll_bwadj), .pll_intfb(pll_intfb), .pll_bypass(pll_bypass),
      .pll_reset(pll_reset), .pll_pwrdn(pll_pwrdn), .clk_sel(clk_sel),
      .locked(locked), .busy(busy), .err(err), .relock_cnt(relock_cnt)
   );

   assign act_cfg = {pll_clkr, pll_clkf, pll_clkod, pll_bwadj, pll_intfb, pll_bypass};

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_chk = 0, n_err = 0;
   sb_t  sb[$];
   vec_t tbl[4];
   int   t_rst_fall = -1, t_sel_rise = -1;
   logic prev_rst = 1'b1, prev_sel = 1'b0;

   // Edge numbers of the last pll_reset release and clk_sel switch to the PLL.
   always @(negedge clk) begin
      if (prev_rst && !pll_reset) t_rst_fall = cyc;
      if (!prev_sel && clk_sel) t_sel_rise = cyc;
      prev_rst = pll_reset;
      prev_sel = clk_sel;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic cfg_t mk_cfg(input int r, input int f, input int o, input int b,
                                   input logic i, input logic y);
      cfg_t c;
      c.clkr   = 4'(r);
      c.clkf   = 6'(f);
      c.clkod  = 4'(o);
      c.bwadj  = 6'(b);
      c.intfb  = i;
      c.bypass = y;
      return c;
   endfunction

   task automatic expect_done(input int dc, input int rf, input int sr, input logic lk,
                              input logic er, input logic pd, input cfg_t c);
      sb_t x;
      x.done_cyc = dc; x.rst_fall = rf; x.sel_rise = sr;
      x.locked = lk; x.err = er; x.pwrdn = pd; x.cfg = c;
      sb.push_back(x);
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_ctl"}, {pll_pwrdn, pll_reset, clk_sel, locked, busy, err, req_ready}, 7'b1100001);
      chk({nm, "_relock"}, relock_cnt, 0);
      chk({nm, "_cfg"}, act_cfg, 0);
   endtask

   task automatic send(input logic pwrdn, input cfg_t c, input logic with_slip, output int acc);
      int n = 0;
      req_pwrdn = pwrdn;
      {req_clkr, req_clkf, req_clkod, req_bwadj, req_intfb, req_bypass} = c;
      req_valid = 1'b1;
      fbslip = with_slip;
      while (!req_ready && n < 200) begin tick(); n++; end
      chk("send_ready", req_ready, 1);
      tick();
      acc = cyc;
      req_valid = 1'b0;
      fbslip = 1'b0;
      chk("acc_err", err, 0);
      chk("acc_busy", busy, 1);
      chk("acc_ready", req_ready, 0);
      chk("acc_locked", locked, 0);
   endtask

   // Runs to the end of a sequence, offering a stray request the whole time.
   task automatic finish_req(input string nm, input int acc, input int s0, input int s1, input int s2);
      sb_t x;
      int  n = 0, bad = 0;
      req_pwrdn = 1'b0;
      {req_clkr, req_clkf, req_clkod, req_bwadj, req_intfb, req_bypass} = mk_cfg(7, 7, 7, 7, 0, 0);
      req_valid = 1'b1;
      do begin
         rfslip = (cyc - acc == s0);
         fbslip = (cyc - acc == s1) || (cyc - acc == s2);
         tick();
         n++;
         if (busy && req_ready) bad++;
      end while (busy && n < 5000);
      req_valid = 1'b0;
      rfslip = 1'b0;
      fbslip = 1'b0;
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_held_off"}, bad, 0);
      chk({nm, "_sb"}, sb.size() > 0, 1);
      if (sb.size() > 0) begin
         x = sb.pop_front();
         chk({nm, "_done_cyc"}, cyc, x.done_cyc);
         chk({nm, "_locked"}, locked, x.locked);
         chk({nm, "_clk_sel"}, clk_sel, x.locked);
         chk({nm, "_err"}, err, x.err);
         chk({nm, "_pwrdn"}, pll_pwrdn, x.pwrdn);
         chk({nm, "_ready"}, req_ready, 1);
         chk({nm, "_cfg"}, act_cfg, x.cfg);
         if (x.rst_fall >= 0) chk({nm, "_rst_fall"}, t_rst_fall, x.rst_fall);
         if (x.sel_rise >= 0) chk({nm, "_sel_rise"}, t_sel_rise, x.sel_rise);
      end
   endtask

   task automatic relock(input int exp_cnt, input cfg_t c);
      int s;
      fbslip = 1'b1;
      tick();
      fbslip = 1'b0;
      s = cyc;
      chk("relock_locked", locked, 0);
      chk("relock_clk_sel", clk_sel, 0);
      chk("relock_cnt", relock_cnt, exp_cnt);
      expect_done(s + 40, s + 6, s + 38, 1'b1, 1'b0, 1'b0, c);
      finish_req("relock", s, -1, -1, -1);
   endtask

   initial begin
      int   acc, rf;
      cfg_t c;

      tbl[0] = '{1'b0, mk_cfg(1, 24, 2, 5, 0, 0), 40, 6, 38, 1'b1, 1'b0, mk_cfg(1, 24, 2, 5, 0, 0)};
      tbl[1] = '{1'b1, mk_cfg(15, 63, 15, 63, 1, 1), 2, -1, -1, 1'b0, 1'b1, mk_cfg(1, 24, 2, 5, 0, 0)};
      tbl[2] = '{1'b0, mk_cfg(3, 10, 1, 7, 1, 1), 8, -1, 6, 1'b1, 1'b0, mk_cfg(3, 10, 1, 7, 1, 1)};
      tbl[3] = '{1'b0, mk_cfg(2, 40, 4, 9, 1, 0), 40, 6, 38, 1'b1, 1'b0, mk_cfg(2, 40, 4, 9, 1, 0)};

      repeat (3) tick();
      rst = 1'b0;
      chk_reset("reset");

      for (int i = 0; i < 4; i++) begin
         send(tbl[i].pwrdn, tbl[i].req, 1'b0, acc);
         rf = (tbl[i].rst_fall < 0) ? -1 : acc + tbl[i].rst_fall;
         expect_done(acc + tbl[i].lat, rf, (tbl[i].sel_rise < 0) ? -1 : acc + tbl[i].sel_rise,
                     tbl[i].x_locked, 1'b0, tbl[i].x_pwrdn, tbl[i].x_cfg);
         finish_req($sformatf("vec%0d", i), acc, -1, -1, -1);
         if (tbl[i].req.bypass && !tbl[i].pwrdn) begin
            rfslip = 1'b1;
            tick();
            rfslip = 1'b0;
            tick();
            chk("bypass_slip_locked", locked, 1);
            chk("bypass_slip_busy", busy, 0);
            chk("bypass_slip_relock", relock_cnt, 0);
         end
      end

      // One slip 20 cycles into the lock window delays lock by 20.
      c = mk_cfg(4, 30, 3, 11, 0, 0);
      send(1'b0, c, 1'b0, acc);
      expect_done(acc + 60, acc + 6, acc + 58, 1'b1, 1'b0, 1'b0, c);
      finish_req("slip20", acc, 25, -1, -1);

      // Third slip in the lock window ends in ERROR.
      c = mk_cfg(5, 33, 1, 2, 1, 0);
      send(1'b0, c, 1'b0, acc);
      expect_done(acc + 17, acc + 6, -1, 1'b0, 1'b1, 1'b0, c);
      finish_req("slip3", acc, 8, 12, 16);
      chk("err_pll_reset", pll_reset, 1);

      c = mk_cfg(1, 24, 2, 5, 0, 0);
      send(1'b0, c, 1'b0, acc);
      expect_done(acc + 40, acc + 6, acc + 38, 1'b1, 1'b0, 1'b0, c);
      finish_req("after_err", acc, -1, -1, -1);

      // Request and slip in the same LOCKED cycle: request wins, no relock.
      c = mk_cfg(6, 20, 2, 3, 1, 0);
      send(1'b0, c, 1'b1, acc);
      chk("race_relock", relock_cnt, 0);
      expect_done(acc + 40, acc + 6, acc + 38, 1'b1, 1'b0, 1'b0, c);
      finish_req("race", acc, -1, -1, -1);

      for (int i = 1; i <= 256; i++) relock((i > 255) ? 255 : i, c);

      send(1'b0, mk_cfg(2, 12, 1, 4, 0, 0), 1'b0, acc);
      while (cyc < acc + 10) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset("rst_lock_wait");

      send(1'b0, mk_cfg(2, 12, 1, 4, 0, 0), 1'b0, acc);
      while (cyc < acc + 38) tick();
      chk("in_sel_pll", clk_sel, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk_reset("rst_sel_pll");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
